// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package inst_fetch_queue_pkg;

  // Fetch FSM; explicit encodings match the legacy S_REQ/S_WAIT/S_DROP values.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // no request outstanding
    S_WAIT = 2'd1,  // one request outstanding, data wanted
    S_DROP = 2'd2   // one request outstanding, data stale
  } fetch_state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // One queue entry: instruction word and the PC it was fetched from.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle between the fetch queue, EX redirect, instruction memory
// and the ID stage. The fetch queue uses the master view.
interface inst_fetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output out_valid, out_inst, out_pc,
    input  out_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  out_valid, out_inst, out_pc,
    output out_ready
  );
endinterface

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// fetch_fifo: DEPTH x WIDTH synchronous FIFO with synchronous flush and an
// occupancy count. Flush overrides push/pop; a push into a full FIFO is only
// accepted when a pop frees a slot in the same cycle.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Qualify push/pop against occupancy and flush.
  always_comb begin
    w_do_pop  = i_pop && (r_count != '0) && !i_flush;
    w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop) && !i_flush;
  end

  // Pointer and count bookkeeping; power-of-two depth lets pointers wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential PC generation, one-at-a-time instruction
// memory requests, and an in-order (inst, pc) queue drained by ID.
// EX redirects squash the queue and restart fetch at the new PC.
// Optional macro FETCH_BYPASS_EN: an empty-queue response is handed to ID in
// its arrival cycle when ID is ready, instead of going through the queue.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                  clk,
  input logic                  rst,
  inst_fetch_queue_if.master   bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_state_e  r_state;
  fetch_state_e  w_next_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;

  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_wentry;
  logic          w_req;
  logic          w_accept;
  logic          w_resp;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic          w_head_valid;

  // Request, response and queue handshake decode.
  always_comb begin
    w_head_valid = (w_count != '0) && !bus.redirect_valid;
    w_req        = !rst && (r_state == S_REQ) && !bus.redirect_valid && (w_count < FULL_CNT);
    w_accept     = w_req && bus.imem_ready;
    w_resp       = bus.imem_rvalid && (r_state == S_WAIT) && !bus.redirect_valid;
`ifdef FETCH_BYPASS_EN
    w_bypass     = w_resp && (w_count == '0) && bus.out_ready;
`else
    w_bypass     = 1'b0;
`endif
    w_push       = w_resp && !w_bypass;
    w_pop        = w_head_valid && bus.out_ready;
    w_wentry     = '{inst: bus.imem_rdata, pc: r_req_pc};
  end

  // Next FSM state; a redirect during an outstanding request forces the
  // response to be drained as stale unless it arrives in the same cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_REQ:   if (w_accept) w_next_state = S_WAIT;
      S_WAIT:  begin
        if (bus.imem_rvalid)         w_next_state = S_REQ;
        else if (bus.redirect_valid) w_next_state = S_DROP;
      end
      S_DROP:  if (bus.imem_rvalid) w_next_state = S_REQ;
      default: w_next_state = S_REQ;
    endcase
  end

  // FSM state, fetch PC and PC of the outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      if (bus.redirect_valid) begin
        r_fetch_pc <= word_align(bus.redirect_pc);
      end else if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_req_pc   <= r_fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.redirect_valid),
    .i_push  (w_push),
    .i_wdata (w_wentry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_fetch_pc;
  assign bus.out_valid = w_head_valid || w_bypass;
  assign bus.out_inst  = w_head_valid ? w_head.inst : (w_bypass ? bus.imem_rdata : INST_NOP);
  assign bus.out_pc    = w_head_valid ? w_head.pc   : (w_bypass ? r_req_pc       : 32'h0);
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: a per-cycle vector table for the basic
// fetch flow, then scripted sequences against a latency-configurable memory.
module tb_inst_fetch_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  inst_fetch_queue_if bus();

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_applied = 0;
  int n_miss    = 0;

  // Response source: table stimulus or the memory model.
  logic        m_en = 1'b0;
  int          m_lat = 1;
  logic        m_rvalid, t_rvalid;
  logic [31:0] m_rdata, t_rdata;
  assign bus.imem_rvalid = m_en ? m_rvalid : t_rvalid;
  assign bus.imem_rdata  = m_en ? m_rdata  : t_rdata;

  logic [31:0] acc_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_inst_q[$];

  // Memory model: returns addr-as-data m_lat cycles after acceptance; also logs
  // accepted addresses and consumed instructions.
  initial begin : mem_model
    logic        pend;
    int          cnt;
    logic [31:0] addr;
    pend = 1'b0; cnt = 0; addr = '0; m_rvalid = 1'b0; m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      m_rvalid = 1'b0;
      if (pend) begin
        if (cnt == 1) begin
          m_rvalid = 1'b1; m_rdata = addr; pend = 1'b0;
        end else cnt--;
      end
      @(negedge clk);
      if (bus.imem_req && bus.imem_ready) begin
        acc_q.push_back(bus.imem_addr);
        if (m_en) begin pend = 1'b1; cnt = m_lat; addr = bus.imem_addr; end
      end
      if (bus.out_valid && bus.out_ready) begin
        pop_pc_q.push_back(bus.out_pc);
        pop_inst_q.push_back(bus.out_inst);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int idx);
    if (idx < 0 || idx >= q.size()) return 32'hDEAD_BEEF;
    return q[idx];
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'b0, bus.imem_req},  32'h0);
    chk({tag, "_addr"},  bus.imem_addr,          32'h0);
    chk({tag, "_ov"},    {31'b0, bus.out_valid}, 32'h0);
    chk({tag, "_inst"},  bus.out_inst,           NOP);
    chk({tag, "_pc"},    bus.out_pc,             32'h0);
  endtask

  // Hold reset for a few cycles, check reset outputs, release mid-cycle.
  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.imem_ready = 1'b0; bus.out_ready = 1'b0;
    t_rvalid = 1'b0; t_rdata = '0;
    repeat (4) @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    rst = 1'b0;
  endtask

  // One cycle: drive inputs just after the edge, return after the mid-cycle sample.
  task automatic cyc(input logic rdy, input logic ordy, input logic rdv, input logic [31:0] rpc);
    @(posedge clk); #1;
    bus.imem_ready = rdy; bus.out_ready = ordy;
    bus.redirect_valid = rdv; bus.redirect_pc = rpc;
    @(negedge clk); #1;
  endtask

  typedef struct {
    logic        rdv;   logic [31:0] rpc;
    logic        rdy;   logic        rv;   logic [31:0] rdata; logic ordy;
    logic        e_req; logic [31:0] e_addr;
    logic        e_ov;  logic [31:0] e_inst; logic [31:0] e_pc;
    int          bp;    // bypass build: 1 = shown this cycle, 2 = not queued
  } vec_t;

  vec_t vecs[9];
  int   base_a, base_p, found;
  logic [31:0] e_inst, e_pc;
  logic        e_ov;

  initial begin
    rst = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.imem_ready = 1'b0; bus.out_ready = 1'b0;
    t_rvalid = 1'b0; t_rdata = '0;

    // 1-cycle memory, addr-as-data, then a redirect to 0x41 (aligned to 0x40).
    vecs[0] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0,  1'b0, NOP,   32'h0, 0};
    vecs[1] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h4,  1'b0, NOP,   32'h0, 1};
    vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4,  1'b1, 32'h0, 32'h0, 2};
    vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 32'h8,  1'b0, NOP,   32'h0, 1};
    vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4, 32'h4, 2};
    vecs[5] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'hC,  1'b0, NOP,   32'h0, 1};
    vecs[6] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h8, 32'h8, 2};
    vecs[7] = '{1'b1, 32'h41, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'hC,  1'b0, NOP,   32'h0, 0};
    vecs[8] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 1'b0, NOP,   32'h0, 0};

    m_en = 1'b0;
    do_reset();
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      bus.redirect_valid = vecs[i].rdv; bus.redirect_pc = vecs[i].rpc;
      bus.imem_ready = vecs[i].rdy; bus.out_ready = vecs[i].ordy;
      t_rvalid = vecs[i].rv; t_rdata = vecs[i].rdata;
      e_ov = vecs[i].e_ov; e_inst = vecs[i].e_inst; e_pc = vecs[i].e_pc;
`ifdef FETCH_BYPASS_EN
      if (vecs[i].bp == 1) begin e_ov = 1'b1; e_inst = vecs[i].rdata; e_pc = vecs[i].rdata; end
      else if (vecs[i].bp == 2) begin e_ov = 1'b0; e_inst = NOP; e_pc = 32'h0; end
`endif
      @(negedge clk); #1;
      chk($sformatf("v%0d_req", i),  {31'b0, bus.imem_req},  {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i), bus.imem_addr,          vecs[i].e_addr);
      chk($sformatf("v%0d_ov", i),   {31'b0, bus.out_valid}, {31'b0, e_ov});
      chk($sformatf("v%0d_inst", i), bus.out_inst,           e_inst);
      chk($sformatf("v%0d_pc", i),   bus.out_pc,             e_pc);
    end
    t_rvalid = 1'b0;

    // Full queue: ID stalled, then drained in order and fetch resumes at 0x10.
    m_en = 1'b1; m_lat = 1;
    do_reset();
    base_a = acc_q.size(); base_p = pop_pc_q.size();
    repeat (20) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("full_acc_cnt", acc_q.size() - base_a, 4);
    chk("full_req_low", {31'b0, bus.imem_req}, 32'h0);
    chk("full_head_pc", bus.out_pc, 32'h0);
    repeat (20) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain_pc%0d", k),   q_at(pop_pc_q, base_p + k),   32'(k * 4));
      chk($sformatf("drain_inst%0d", k), q_at(pop_inst_q, base_p + k), 32'(k * 4));
    end
    chk("resume_addr", q_at(acc_q, base_a + 4), 32'h10);

    // Redirect to 0x103 while the 0x8 request is outstanding (3-cycle memory).
    m_lat = 3;
    do_reset();
    base_a = acc_q.size(); base_p = pop_pc_q.size();
    for (int k = 0; k < 40 && acc_q.size() < base_a + 3; k++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("drop_acc8", q_at(acc_q, base_a + 2), 32'h8);
    cyc(1'b1, 1'b1, 1'b1, 32'h103);
    chk("drop_redir_ov", {31'b0, bus.out_valid}, 32'h0);
    chk("drop_redir_req", {31'b0, bus.imem_req}, 32'h0);
    repeat (15) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("drop_next_addr", q_at(acc_q, base_a + 3), 32'h100);
    chk("drop_pop0", q_at(pop_pc_q, base_p), 32'h0);
    chk("drop_pop1", q_at(pop_pc_q, base_p + 1), 32'h4);
    chk("drop_pop2", q_at(pop_pc_q, base_p + 2), 32'h100);
    chk("drop_inst2", q_at(pop_inst_q, base_p + 2), 32'h100);

    // Redirect in the same cycle as the response for 0x4.
    m_lat = 1;
    do_reset();
    base_a = acc_q.size(); base_p = pop_pc_q.size();
    for (int k = 0; k < 40 && acc_q.size() < base_a + 2; k++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("same_acc4", q_at(acc_q, base_a + 1), 32'h4);
    cyc(1'b1, 1'b1, 1'b1, 32'h200);
    chk("same_redir_ov", {31'b0, bus.out_valid}, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("same_next_req", {31'b0, bus.imem_req}, 32'h1);
    chk("same_next_addr", bus.imem_addr, 32'h200);
    repeat (10) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    found = 0;
    for (int k = base_p; k < pop_pc_q.size(); k++) if (pop_pc_q[k] == 32'h4) found++;
    chk("same_no_stale", 32'(found), 32'h0);
    chk("same_pop1", q_at(pop_pc_q, base_p + 1), 32'h200);

    // imem_ready held low: request and address held stable.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      chk($sformatf("hold_req%0d", k),  {31'b0, bus.imem_req}, 32'h1);
      chk($sformatf("hold_addr%0d", k), bus.imem_addr,         32'h0);
    end
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_BYPASS_EN
    chk("lat_rv_ov", {31'b0, bus.out_valid}, 32'h1);
    chk("lat_rv_pc", bus.out_pc, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("lat_next_ov", {31'b0, bus.out_valid}, 32'h0);
`else
    chk("lat_rv_ov", {31'b0, bus.out_valid}, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("lat_next_ov", {31'b0, bus.out_valid}, 32'h1);
    chk("lat_next_pc", bus.out_pc, 32'h0);
`endif

    // Reset while a request is outstanding; the stray response is ignored.
    m_lat = 3;
    do_reset();
    base_p = pop_pc_q.size();
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0; bus.imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      chk($sformatf("stray_ov%0d", k),  {31'b0, bus.out_valid}, 32'h0);
      chk($sformatf("stray_addr%0d", k), bus.imem_addr,         32'h0);
    end
    repeat (12) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("post_pop0", q_at(pop_pc_q, base_p),     32'h0);
    chk("post_pop1", q_at(pop_pc_q, base_p + 1), 32'h4);
    chk("post_inst1", q_at(pop_inst_q, base_p + 1), 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end
endmodule
